data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Byte-addressed, little-endian data memory for the RISC-V LITE core, driven from the datapath's MEM stage.
- Supports RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) selected by funct3.
- Reads are combinational; writes are synchronous.
- Sits between the datapath's DRAM-side outputs and its fromDRAM input.

Parameters:
- DEPTH, 1024, number of 32-bit words stored.
- ADDR_W, 10, word-index width; must equal log2(DEPTH).
- BASE_ADDR, 32'h1001_0000, byte address mapped to word 0 (start of the data segment).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  access strobe; no read or write occurs when 0.
- datamem_address  input  32  byte address.
- datamem_datain  input  32  store data; only the low bits are used for SB/SH.
- datamem_negread_write  input  1  0 = read, 1 = write.
- funct3  input  3  access width/sign code, RV32I encoding.
- datamem_dataout  output  32  load result.

Behaviour:
- Address decode:
  - off = datamem_address - BASE_ADDR (32-bit wrap).
  - word index = off[ADDR_W+1:2]; upper bits are ignored, so accesses alias modulo DEPTH words.
  - lane = off[1:0].
- Reset:
  - While reset = 0, every memory word is cleared to 0 asynchronously and writes are blocked.
  - datamem_dataout = 0 during reset.
  - Deassertion needs no sync stage inside the block.
- Read (combinational, same cycle) when enable = 1 and negread_write = 0:
  - 000 LB: byte at lane, sign-extended.
  - 001 LH: halfword at off[1] (bytes 0-1 or 2-3), sign-extended; off[0] ignored.
  - 010 LW: full word; off[1:0] ignored.
  - 100 LBU: byte at lane, zero-extended.
  - 101 LHU: halfword at off[1], zero-extended.
  - 011/110/111: output 0.
- When enable = 0 or negread_write = 1: datamem_dataout = 0.
- Write (rising edge of clk) when reset = 1, enable = 1 and negread_write = 1:
  - 000 SB: datain[7:0] into byte lane; other bytes unchanged.
  - 001 SH: datain[15:0] into the half chosen by off[1]; other half unchanged.
  - 010 SW: full word written.
  - Any other code: no write.
- Read-after-write:
  - A read of the same word in the cycle after the write returns the new data.
  - Within the write cycle itself, dataout is 0 because the access is a write.
- Byte order is little-endian: byte lane 0 = bits [7:0].
- No error or exception outputs; misaligned accesses are resolved by the lane rules above, never trapped.
- Single port: exactly one access per cycle.

Test Plan:
- Reset clears memory: write SW 0xDEADBEEF at BASE_ADDR, assert reset = 0 for 2 cycles, release, then LW BASE_ADDR -> dataout = 0x00000000.
- Word round-trip: SW 0x12345678 at BASE_ADDR+8, next cycle LW BASE_ADDR+8 -> 0x12345678; LW BASE_ADDR+0 -> 0.
- Byte and half reads of that word:
  - LB BASE+8 -> 0x00000078; LB BASE+11 -> 0x00000012.
  - LH BASE+10 -> 0x00001234.
  - After SW 0x80F0FF80: LB lane 0 -> 0xFFFFFF80; LBU lane 0 -> 0x00000080; LH lane 2 -> 0xFFFF80F0; LHU lane 2 -> 0x000080F0.
- Partial stores:
  - Word = 0x11223344, SB 0xAB at lane 1 -> LW = 0x1122AB44.
  - SH 0xCDEF at lane 2 -> LW = 0xCDEFAB44.
- Gating and invalid codes:
  - enable = 0 with negread_write = 1 and SW data -> memory unchanged.
  - funct3 = 011 read -> dataout 0; funct3 = 111 write -> memory unchanged.
  - Read with enable = 0 -> dataout 0.
- Aliasing: SW 0xA5A5A5A5 at BASE_ADDR + 4*DEPTH -> LW BASE_ADDR returns 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory for the RISC-V LITE MEM stage.
// Combinational RV32I loads, synchronous byte/half/word stores, async clear on reset.
module data_mem #(
  parameter int          DEPTH     = 1024,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] datamem_address,
  input  logic [31:0] datamem_datain,
  input  logic        datamem_negread_write,
  input  logic [2:0]  funct3,
  output logic [31:0] datamem_dataout
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [31:0] mem [DEPTH];

  logic [31:0]       off;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       wr_word;
  logic              wr_en;
  logic              rd_en;
  logic              unused_off;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sign);
    return sign ? {{24{b[7]}}, b} : {24'h0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sign);
    return sign ? {{16{h[15]}}, h} : {16'h0, h};
  endfunction

  // Upper offset bits are dropped so the address space aliases modulo DEPTH words.
  assign off        = datamem_address - BASE_ADDR;
  assign idx        = off[ADDR_W+1:2];
  assign lane       = off[1:0];
  assign unused_off = ^off[31:ADDR_W+2];

  assign rd_word = mem[idx];
  assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (lane)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  assign rd_en = reset && enable && !datamem_negread_write;

  always_comb begin
    datamem_dataout = 32'h0;
    if (rd_en) begin
      case (funct3)
        F3_B:    datamem_dataout = ext_byte(rd_byte, 1'b1);
        F3_H:    datamem_dataout = ext_half(rd_half, 1'b1);
        F3_W:    datamem_dataout = rd_word;
        F3_BU:   datamem_dataout = ext_byte(rd_byte, 1'b0);
        F3_HU:   datamem_dataout = ext_half(rd_half, 1'b0);
        default: datamem_dataout = 32'h0;
      endcase
    end
  end

  // Partial stores merge the new lane(s) into the currently stored word.
  always_comb begin
    wr_word = rd_word;
    wr_en   = 1'b0;
    if (reset && enable && datamem_negread_write) begin
      case (funct3)
        F3_B: begin
          wr_en = 1'b1;
          case (lane)
            2'd0: wr_word[7:0]   = datamem_datain[7:0];
            2'd1: wr_word[15:8]  = datamem_datain[7:0];
            2'd2: wr_word[23:16] = datamem_datain[7:0];
            2'd3: wr_word[31:24] = datamem_datain[7:0];
            default: wr_word = rd_word;
          endcase
        end
        F3_H: begin
          wr_en = 1'b1;
          if (off[1]) wr_word[31:16] = datamem_datain[15:0];
          else        wr_word[15:0]  = datamem_datain[15:0];
        end
        F3_W: begin
          wr_en   = 1'b1;
          wr_word = datamem_datain;
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (wr_en) begin
      mem[idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: reset clear, load extensions, partial stores,
// gating, invalid funct3 codes and address aliasing.
module tb_data_mem;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] datamem_address;
  logic [31:0] datamem_datain;
  logic        datamem_negread_write;
  logic [2:0]  funct3;
  logic [31:0] datamem_dataout;

  int tests = 0;
  int fails = 0;

  data_mem #(.DEPTH(1024), .ADDR_W(10), .BASE_ADDR(BASE)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable                (enable),
    .datamem_address       (datamem_address),
    .datamem_datain        (datamem_datain),
    .datamem_negread_write (datamem_negread_write),
    .funct3                (funct3),
    .datamem_dataout       (datamem_dataout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp);
    tests++;
    assert (datamem_dataout === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, datamem_dataout, exp);
    end
  endtask

  task automatic idle();
    enable                = 1'b0;
    datamem_negread_write = 1'b0;
    datamem_address       = 32'h0;
    datamem_datain        = 32'h0;
    funct3                = 3'b000;
  endtask

  // Drive a store for one full clock period; dataout must read 0 during it.
  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] f3, input logic en);
    @(negedge clk);
    enable                = en;
    datamem_negread_write = 1'b1;
    datamem_address       = addr;
    datamem_datain        = data;
    funct3                = f3;
    #1;
    check("write_cycle_out0", 32'h0);
    @(negedge clk);
    idle();
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] f3,
                      input logic en, input string tag, input logic [31:0] exp);
    @(negedge clk);
    enable                = en;
    datamem_negread_write = 1'b0;
    datamem_address       = addr;
    funct3                = f3;
    #1;
    check(tag, exp);
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    enable = 1'b1; funct3 = 3'b010; datamem_address = BASE;
    #1;
    check("reset_out0", 32'h0);
    idle();
    reset = 1'b1;

    store(BASE, 32'hDEADBEEF, 3'b010, 1'b1);
    load(BASE, 3'b010, 1'b1, "lw_before_reset", 32'hDEADBEEF);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    load(BASE, 3'b010, 1'b1, "reset_clears", 32'h0);

    store(BASE + 8, 32'h12345678, 3'b010, 1'b1);
    load(BASE + 8,  3'b010, 1'b1, "lw_roundtrip", 32'h12345678);
    load(BASE + 0,  3'b010, 1'b1, "lw_other_word", 32'h0);
    load(BASE + 8,  3'b000, 1'b1, "lb_lane0", 32'h00000078);
    load(BASE + 11, 3'b000, 1'b1, "lb_lane3", 32'h00000012);
    load(BASE + 10, 3'b001, 1'b1, "lh_upper", 32'h00001234);
    load(BASE + 9,  3'b101, 1'b1, "lhu_odd_low", 32'h00005678);

    store(BASE + 12, 32'h80F0FF80, 3'b010, 1'b1);
    load(BASE + 12, 3'b000, 1'b1, "lb_sext", 32'hFFFFFF80);
    load(BASE + 12, 3'b100, 1'b1, "lbu_zext", 32'h00000080);
    load(BASE + 14, 3'b001, 1'b1, "lh_sext", 32'hFFFF80F0);
    load(BASE + 14, 3'b101, 1'b1, "lhu_zext", 32'h000080F0);
    load(BASE + 13, 3'b000, 1'b1, "lb_lane1_sext", 32'hFFFFFFFF);
    load(BASE + 13, 3'b100, 1'b1, "lbu_lane1", 32'h000000FF);
    load(BASE + 12, 3'b001, 1'b1, "lh_low_sext", 32'hFFFFFF80);

    store(BASE + 16, 32'h11223344, 3'b010, 1'b1);
    store(BASE + 17, 32'hFFFFFFAB, 3'b000, 1'b1);
    load(BASE + 16, 3'b010, 1'b1, "sb_lane1", 32'h1122AB44);
    store(BASE + 18, 32'hFFFFCDEF, 3'b001, 1'b1);
    load(BASE + 16, 3'b010, 1'b1, "sh_upper", 32'hCDEFAB44);
    load(BASE + 19, 3'b010, 1'b1, "lw_misaligned", 32'hCDEFAB44);
    store(BASE + 16, 32'h00009999, 3'b001, 1'b1);
    load(BASE + 16, 3'b010, 1'b1, "sh_lower", 32'hCDEF9999);

    store(BASE + 16, 32'h00000000, 3'b010, 1'b0);
    load(BASE + 16, 3'b010, 1'b1, "en0_no_write", 32'hCDEF9999);
    load(BASE + 16, 3'b011, 1'b1, "f3_011_read0", 32'h0);
    load(BASE + 16, 3'b110, 1'b1, "f3_110_read0", 32'h0);
    store(BASE + 16, 32'h00000000, 3'b111, 1'b1);
    load(BASE + 16, 3'b010, 1'b1, "f3_111_no_write", 32'hCDEF9999);
    store(BASE + 16, 32'h00000000, 3'b100, 1'b1);
    load(BASE + 16, 3'b010, 1'b1, "f3_100_no_write", 32'hCDEF9999);
    load(BASE + 16, 3'b010, 1'b0, "en0_read0", 32'h0);

    store(BASE + 32'd4096, 32'hA5A5A5A5, 3'b010, 1'b1);
    load(BASE, 3'b010, 1'b1, "alias_high", 32'hA5A5A5A5);
    store(BASE - 4, 32'h5A5A0F0F, 3'b010, 1'b1);
    load(BASE + 32'd4092, 3'b010, 1'b1, "alias_below_base", 32'h5A5A0F0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
